// File: rtl/clock_time_keeper_if.sv
// ---------------------------------------------------------------------------
// clock_time_keeper_if
// Bundle between the time keeper and its neighbours: the two user button
// pulses going in, and the six 7-segment digit codes plus the three per-field
// blank requests going out to the scanned display driver.
//
//   btn_mode      button pulse, advances RUN -> SET_H -> SET_M -> SET_S -> RUN
//   btn_up        button pulse, increments the field being set
//   data1..data6  7-bit segment codes (bit6=a .. bit0=g), HH MM SS left to right
//   h, m, s       blank request for the hours / minutes / seconds pair
//
// Modports: master = button source / display consumer, slave = time keeper.
// ---------------------------------------------------------------------------
interface clock_time_keeper_if;
    logic       btn_mode;
    logic       btn_up;
    logic [6:0] data1;
    logic [6:0] data2;
    logic [6:0] data3;
    logic [6:0] data4;
    logic [6:0] data5;
    logic [6:0] data6;
    logic       h;
    logic       m;
    logic       s;

    modport master (
        output btn_mode, btn_up,
        input  data1, data2, data3, data4, data5, data6, h, m, s
    );

    modport slave (
        input  btn_mode, btn_up,
        output data1, data2, data3, data4, data5, data6, h, m, s
    );
endinterface

// File: rtl/clock_time_keeper.sv
// ---------------------------------------------------------------------------
// clock_time_keeper
// 24-hour HH:MM:SS time source for the six-digit scanned 7-segment driver.
// Time advances once every TICK_DIV clocks in RUN mode; the three SET modes
// freeze time and let btn_up step the selected field (no carry). The field
// being set blinks with a half-period of BLINK_DIV clocks.
//
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high reset
//   bus    clock_time_keeper_if.slave: btn_mode/btn_up in, data1..data6 and
//          h/m/s out (segment codes and flags decode straight from registers)
// ---------------------------------------------------------------------------
module clock_time_keeper #(
    parameter int TICK_DIV  = 1000,
    parameter int BLINK_DIV = 500
) (
    input  logic               clock,
    input  logic               reset,
    clock_time_keeper_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    // Active-high 7-segment code, bit6=a .. bit0=g.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1111110;
            4'd1:    code = 7'b0110000;
            4'd2:    code = 7'b1101101;
            4'd3:    code = 7'b1111001;
            4'd4:    code = 7'b0110011;
            4'd5:    code = 7'b1011011;
            4'd6:    code = 7'b1011111;
            4'd7:    code = 7'b1110000;
            4'd8:    code = 7'b1111111;
            4'd9:    code = 7'b1111011;
            default: code = 7'b0000000;
        endcase
        return code;
    endfunction

    // Increment a BCD 00..59 pair, wrapping 59 -> 00. Returns {tens, ones}.
    function automatic logic [7:0] inc_sexa(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if (ones == 4'd9) begin
            if (tens == 4'd5) begin
                res = 8'h00;
            end else begin
                res = {tens + 4'd1, 4'd0};
            end
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    // Increment a BCD 00..23 pair, wrapping 23 -> 00. Returns {tens, ones}.
    function automatic logic [7:0] inc_hour(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if ((tens == 4'd2) && (ones == 4'd3)) begin
            res = 8'h00;
        end else if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    mode_t         state_r, state_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [BW-1:0] blink_cnt_r, blink_cnt_s;
    logic          blink_phase_r, blink_phase_s;
    logic [3:0]    hr_t_r, hr_o_r, mn_t_r, mn_o_r, sc_t_r, sc_o_r;
    logic [3:0]    hr_t_s, hr_o_s, mn_t_s, mn_o_s, sc_t_s, sc_o_s;

    logic          mode_adv_s;
    logic          up_acc_s;
    logic          tick_s;
    logic          sec_wrap_s;
    logic          min_wrap_s;

    // Button qualification: a mode press always wins, btn_up only counts while setting.
    always_comb begin
        mode_adv_s = bus.btn_mode;
        up_acc_s   = bus.btn_up & ~bus.btn_mode & (state_r != RUN);
        tick_s     = (state_r == RUN) & (presc_r == PRESC_MAX);
        sec_wrap_s = (sc_t_r == 4'd5) & (sc_o_r == 4'd9);
        min_wrap_s = (mn_t_r == 4'd5) & (mn_o_r == 4'd9);
    end

    // Mode FSM next state.
    always_comb begin
        state_s = state_r;
        if (mode_adv_s) begin
            case (state_r)
                RUN:     state_s = SET_H;
                SET_H:   state_s = SET_M;
                SET_M:   state_s = SET_S;
                SET_S:   state_s = RUN;
                default: state_s = RUN;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Prescaler: counts only in RUN, so re-entering RUN always waits a full period.
    always_comb begin
        presc_s = presc_r;
        if (state_r != RUN) begin
            presc_s = '0;
        end else if (tick_s) begin
            presc_s = '0;
        end else begin
            presc_s = presc_r + PW'(1);
        end
    end

    // Time digits: a tick ripples the carry through all fields in one edge,
    // a set press touches only the selected field.
    always_comb begin
        {hr_t_s, hr_o_s} = {hr_t_r, hr_o_r};
        {mn_t_s, mn_o_s} = {mn_t_r, mn_o_r};
        {sc_t_s, sc_o_s} = {sc_t_r, sc_o_r};
        if (tick_s || (up_acc_s && (state_r == SET_S))) begin
            {sc_t_s, sc_o_s} = inc_sexa(sc_t_r, sc_o_r);
        end else begin
            {sc_t_s, sc_o_s} = {sc_t_r, sc_o_r};
        end
        if ((tick_s && sec_wrap_s) || (up_acc_s && (state_r == SET_M))) begin
            {mn_t_s, mn_o_s} = inc_sexa(mn_t_r, mn_o_r);
        end else begin
            {mn_t_s, mn_o_s} = {mn_t_r, mn_o_r};
        end
        if ((tick_s && sec_wrap_s && min_wrap_s) || (up_acc_s && (state_r == SET_H))) begin
            {hr_t_s, hr_o_s} = inc_hour(hr_t_r, hr_o_r);
        end else begin
            {hr_t_s, hr_o_s} = {hr_t_r, hr_o_r};
        end
    end

    // Blink timer: restarts on any press so the edited field is shown at once.
    always_comb begin
        blink_cnt_s   = blink_cnt_r;
        blink_phase_s = blink_phase_r;
        if (mode_adv_s || up_acc_s) begin
            blink_cnt_s   = '0;
            blink_phase_s = 1'b0;
        end else if (blink_cnt_r == BLINK_MAX) begin
            blink_cnt_s   = '0;
            blink_phase_s = ~blink_phase_r;
        end else begin
            blink_cnt_s   = blink_cnt_r + BW'(1);
            blink_phase_s = blink_phase_r;
        end
    end

    // Mode state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers: prescaler, blink timer and the six BCD digits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_r       <= '0;
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
            hr_t_r        <= 4'd0;
            hr_o_r        <= 4'd0;
            mn_t_r        <= 4'd0;
            mn_o_r        <= 4'd0;
            sc_t_r        <= 4'd0;
            sc_o_r        <= 4'd0;
        end else begin
            presc_r       <= presc_s;
            blink_cnt_r   <= blink_cnt_s;
            blink_phase_r <= blink_phase_s;
            hr_t_r        <= hr_t_s;
            hr_o_r        <= hr_o_s;
            mn_t_r        <= mn_t_s;
            mn_o_r        <= mn_o_s;
            sc_t_r        <= sc_t_s;
            sc_o_r        <= sc_o_s;
        end
    end

    assign bus.data1 = seg7(hr_t_r);
    assign bus.data2 = seg7(hr_o_r);
    assign bus.data3 = seg7(mn_t_r);
    assign bus.data4 = seg7(mn_o_r);
    assign bus.data5 = seg7(sc_t_r);
    assign bus.data6 = seg7(sc_o_r);

    assign bus.h = (state_r == SET_H) & blink_phase_r;
    assign bus.m = (state_r == SET_M) & blink_phase_r;
    assign bus.s = (state_r == SET_S) & blink_phase_r;

endmodule

// File: tb/tb_clock_time_keeper.sv
// ---------------------------------------------------------------------------
// tb_clock_time_keeper
// Self-checking bench for clock_time_keeper with TICK_DIV=4, BLINK_DIV=3.
// A behavioural model (plain integers, modular arithmetic) predicts the
// display every cycle through a scoreboard queue; a table of vectors with
// hand-computed times and flags checks the milestones; a hand sequence
// covers asynchronous reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_clock_time_keeper;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 3;

    logic clock = 1'b0;
    logic reset;

    clock_time_keeper_if bus ();

    clock_time_keeper #(
        .TICK_DIV (TICK_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int mh, mm, ms, mode, presc, bcnt, bph;

    typedef struct packed {
        logic [41:0] data;
        logic [2:0]  flags;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string      name;
        int         nrep;
        bit         bm;
        bit         bu;
        int         nidle;
        int         eh;
        int         em;
        int         es;
        logic [2:0] ef;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [41:0] disp(input int hh, input int mi, input int ss);
        return {seg(hh / 10), seg(hh % 10), seg(mi / 10), seg(mi % 10), seg(ss / 10), seg(ss % 10)};
    endfunction

    function automatic logic [41:0] act_data();
        return {bus.data1, bus.data2, bus.data3, bus.data4, bus.data5, bus.data6};
    endfunction

    function automatic logic [2:0] act_flags();
        return {bus.h, bus.m, bus.s};
    endfunction

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0; mode = 0; presc = 0; bcnt = 0; bph = 0;
    endtask

    // Advance the model by one clock edge with the given buttons and queue the prediction.
    task automatic model_step(input bit bm, input bit bu);
        bit   up_ok;
        int   tot;
        exp_t e;
        up_ok = bu && !bm && (mode != 0);
        if (mode == 0) begin
            if (presc == TICK_DIV - 1) begin
                presc = 0;
                tot = (mh * 3600 + mm * 60 + ms + 1) % 86400;
                mh = tot / 3600;
                mm = (tot / 60) % 60;
                ms = tot % 60;
            end else begin
                presc = presc + 1;
            end
        end else begin
            presc = 0;
        end
        if (up_ok) begin
            if (mode == 1) mh = (mh + 1) % 24;
            if (mode == 2) mm = (mm + 1) % 60;
            if (mode == 3) ms = (ms + 1) % 60;
        end
        if (bm || up_ok) begin
            bcnt = 0;
            bph  = 0;
        end else if (bcnt == BLINK_DIV - 1) begin
            bcnt = 0;
            bph  = 1 - bph;
        end else begin
            bcnt = bcnt + 1;
        end
        if (bm) mode = (mode + 1) % 4;
        e.data  = disp(mh, mm, ms);
        e.flags = {(mode == 1) && (bph == 1), (mode == 2) && (bph == 1), (mode == 3) && (bph == 1)};
        sb_q.push_back(e);
    endtask

    // One clock: drive buttons, predict, wait the edge, compare against the scoreboard.
    task automatic cycle(input bit bm, input bit bu);
        exp_t e;
        bus.btn_mode = bm;
        bus.btn_up   = bu;
        model_step(bm, bu);
        @(posedge clock);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        e = sb_q.pop_front();
        check("sb_data", act_data(), e.data);
        check("sb_flags", {39'd0, act_flags()}, {39'd0, e.flags});
    endtask

    task automatic run(input int nrep, input bit bm, input bit bu, input int nidle);
        for (int r = 0; r < nrep; r++) cycle(bm, bu);
        for (int k = 0; k < nidle; k++) cycle(1'b0, 1'b0);
    endtask

    task automatic expect_time(input string name, input int hh, input int mi, input int ss, input logic [2:0] fl);
        check({name, "_data"}, act_data(), disp(hh, mi, ss));
        check({name, "_flags"}, {39'd0, act_flags()}, {39'd0, fl});
    endtask

    task automatic add_vec(input string name, input int nrep, input bit bm, input bit bu, input int nidle,
                           input int eh, input int em, input int es, input logic [2:0] ef);
        vec_t v;
        v.name = name; v.nrep = nrep; v.bm = bm; v.bu = bu; v.nidle = nidle;
        v.eh = eh; v.em = em; v.es = es; v.ef = ef;
        vecs.push_back(v);
    endtask

    initial begin
        //       name          nrep bm bu idle  hh  mm  ss  flags
        add_vec("tick1",        0, 0, 0,   4,  0,  0,  1, 3'b000);
        add_vec("tick10",       0, 0, 0,  36,  0,  0, 10, 3'b000);
        add_vec("to_set_h",     1, 1, 0,   0,  0,  0, 10, 3'b000);
        add_vec("h_low",        0, 0, 0,   2,  0,  0, 10, 3'b000);
        add_vec("h_high",       0, 0, 0,   1,  0,  0, 10, 3'b100);
        add_vec("h_low2",       0, 0, 0,   3,  0,  0, 10, 3'b000);
        add_vec("frozen",       0, 0, 0, 100,  0,  0, 10, 3'b100);
        add_vec("hr_25",       25, 0, 1,   0,  1,  0, 10, 3'b000);
        add_vec("hr_05",        4, 0, 1,   0,  5,  0, 10, 3'b000);
        add_vec("to_set_m",     1, 1, 0,   0,  5,  0, 10, 3'b000);
        add_vec("min_59",      59, 0, 1,   0,  5, 59, 10, 3'b000);
        add_vec("min_wrap",     1, 0, 1,   0,  5,  0, 10, 3'b000);
        add_vec("m_high",       0, 0, 0,   3,  5,  0, 10, 3'b010);
        add_vec("to_set_s",     1, 1, 0,   0,  5,  0, 10, 3'b000);
        add_vec("sec_59",      49, 0, 1,   0,  5,  0, 59, 3'b000);
        add_vec("to_run",       1, 1, 0,   0,  5,  0, 59, 3'b000);
        add_vec("run_wait",     0, 0, 0,   3,  5,  0, 59, 3'b000);
        add_vec("run_tick",     0, 0, 0,   1,  5,  1,  0, 3'b000);
        add_vec("r_set_h",      1, 1, 0,   0,  5,  1,  0, 3'b000);
        add_vec("r_hr_23",     18, 0, 1,   0, 23,  1,  0, 3'b000);
        add_vec("r_set_m",      1, 1, 0,   0, 23,  1,  0, 3'b000);
        add_vec("r_min_59",    58, 0, 1,   0, 23, 59,  0, 3'b000);
        add_vec("r_set_s",      1, 1, 0,   0, 23, 59,  0, 3'b000);
        add_vec("r_sec_59",    59, 0, 1,   0, 23, 59, 59, 3'b000);
        add_vec("r_to_run",     1, 1, 0,   0, 23, 59, 59, 3'b000);
        add_vec("r_wait",       0, 0, 0,   3, 23, 59, 59, 3'b000);
        add_vec("rollover",     0, 0, 0,   1,  0,  0,  0, 3'b000);
        add_vec("b_set_h",      1, 1, 0,   0,  0,  0,  0, 3'b000);
        add_vec("both",         1, 1, 1,   0,  0,  0,  0, 3'b000);
        add_vec("both_low",     0, 0, 0,   2,  0,  0,  0, 3'b000);
        add_vec("both_m_high",  0, 0, 0,   1,  0,  0,  0, 3'b010);
        add_vec("back_run",     2, 1, 0,   0,  0,  0,  0, 3'b000);
        add_vec("run_up_ign",   1, 0, 1,   0,  0,  0,  0, 3'b000);
        add_vec("run_up_wait",  0, 0, 0,   2,  0,  0,  0, 3'b000);
        add_vec("first_sec",    0, 0, 0,   1,  0,  0,  1, 3'b000);
        add_vec("pre_rst_h",    1, 1, 0,   0,  0,  0,  1, 3'b000);
        add_vec("pre_rst_hi",   0, 0, 0,   3,  0,  0,  1, 3'b100);

        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_up   = 1'b0;
        model_reset();
        #2;
        expect_time("por", 0, 0, 0, 3'b000);
        #6;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i].nrep, vecs[i].bm, vecs[i].bu, vecs[i].nidle);
            expect_time(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ef);
        end

        // Asynchronous reset while setting hours with the blink flag high;
        // a mode press held through reset must not survive it.
        #2;
        reset        = 1'b1;
        bus.btn_mode = 1'b1;
        #1;
        expect_time("rst_async", 0, 0, 0, 3'b000);
        model_reset();
        @(posedge clock);
        #1;
        bus.btn_mode = 1'b0;
        expect_time("rst_hold", 0, 0, 0, 3'b000);
        #4;
        reset = 1'b0;
        run(0, 1'b0, 1'b0, 4);
        expect_time("rst_tick1", 0, 0, 1, 3'b000);
        run(0, 1'b0, 1'b0, 36);
        expect_time("rst_tick10", 0, 0, 10, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_time_keeper.md
Name: clock_time_keeper

Overview:
- Upstream time source for the 6-digit scanned 7-segment display driver.
- Keeps 24-hour HH:MM:SS time from the system clock and lets the user set hours, minutes and seconds with two buttons.
- Drives the driver's six 7-bit digit codes (data1..data6) and its three per-field blink flags (h, m, s).

Parameters:
- TICK_DIV, 1000, clock cycles per second; legal range >= 2.
- BLINK_DIV, 500, clock cycles per blink half-period; legal range >= 2.

Ports:
- clock    in   1  system clock
- reset    in   1  asynchronous, active-high reset
- btn_mode in   1  single-cycle pulse, already debounced/synchronised; advances mode
- btn_up   in   1  single-cycle pulse, already debounced/synchronised; increments selected field
- data1    out  7  hours tens code
- data2    out  7  hours ones code
- data3    out  7  minutes tens code
- data4    out  7  minutes ones code
- data5    out  7  seconds tens code
- data6    out  7  seconds ones code
- h        out  1  hours pair blank request
- m        out  1  minutes pair blank request
- s        out  1  seconds pair blank request

Behaviour:
- Reset (async, immediate):
  - time 00:00:00, mode RUN, prescaler 0, blink counter 0, blink_phase 0.
  - h=m=s=0; data1..data6 = code for 0.
- Storage: six BCD digit registers.
  - Hours 00-23; minutes 00-59; seconds 00-59.
  - No illegal value is reachable.
- Segment codes: active-high, bit6=a ... bit0=g, combinational decode of the digit registers.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Mode FSM states: RUN, SET_H, SET_M, SET_S.
  - btn_mode advances RUN->SET_H->SET_M->SET_S->RUN on the edge where it is sampled high.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - On the edge where prescaler==TICK_DIV-1: prescaler<=0 and seconds+1, with carry into minutes and hours in the same edge.
  - 23:59:59 -> 00:00:00 in one edge; ones 9->0 carries to tens; seconds/minutes 59->00 carries onward.
- SET_x states:
  - Timekeeping frozen; prescaler held at 0.
  - Re-entering RUN starts a full TICK_DIV period before the next second.
  - btn_up increments only the selected field by 1, wrapping 23->00 or 59->00, with no carry into other fields.
- Simultaneous btn_mode and btn_up: mode advance wins; btn_up is ignored that cycle.
- btn_up in RUN: ignored.
- Blink counter:
  - Free-running 0..BLINK_DIV-1; blink_phase toggles on wrap.
  - Any accepted btn_up, and any mode change, clears the blink counter and blink_phase to 0 (field shown immediately).
- Flags (combinational from state and blink_phase):
  - h = (state==SET_H) & blink_phase
  - m = (state==SET_M) & blink_phase
  - s = (state==SET_S) & blink_phase
  - All flags are 0 in RUN. At most one flag is high at any time.
- Output timing: data outputs change in the same cycle the digit registers update, i.e. one clock after the tick/button cycle.
- Reset mid-operation, in any state: immediate return to the reset values above; no pending press is retained.

Test Plan:
- Use TICK_DIV=4 and BLINK_DIV=3 unless stated.
- Reset mid-run -> all six data outputs = 1111110, h=m=s=0; after 4 clocks data6=0110000 (1); after 40 clocks data5=0110000, data6=1111110 (10).
- Rollover: set 23:59:59 via SET states, return to RUN -> after 4 clocks all digits 1111110; no intermediate 24:00:00 code appears on any cycle.
- Set hours:
  - 1 btn_mode pulse -> state SET_H; time stays frozen for 100 clocks.
  - h toggles every 3 clocks, starting 0 for 3 clocks; m=s=0.
  - 25 btn_up pulses from 00 -> hours read 01 (data1=1111110, data2=0110000).
- Minute wrap without carry: SET_M with minutes 59, hours 05, 1 btn_up -> minutes 00, hours still 05; m=0 on the cycle after the press.
- Simultaneous btn_mode+btn_up in SET_H -> state SET_M, hours unchanged, m=0 then 1 after 3 clocks.
- Full cycle: 4 btn_mode pulses -> back in RUN, flags 0; the first second increments exactly 4 clocks after the RUN re-entry edge.
